// File: rtl/start_srl_fifo_ctrl_if.sv
// start_srl_fifo_ctrl_if
// ap_fifo handshake bundle for the start/token FIFO.
//   if_write_ce, if_write, if_din   : write side, driven by the producer
//   if_full_n                       : FIFO can accept a word
//   if_read_ce, if_read             : read side, driven by the consumer
//   if_dout, if_empty_n             : registered head word and its valid flag
//   if_num_data_valid, if_fifo_cap  : occupancy and fixed capacity
// master = producer/consumer side, slave = the FIFO.
interface start_srl_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_num_data_valid;
    logic [ADDR_WIDTH:0]   if_fifo_cap;

    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
    );

    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
    );
endinterface

// File: rtl/start_srl_fifo_ctrl.sv
// start_srl_fifo_ctrl
// Shift-register start/token FIFO with a one-entry registered output stage.
// Capacity is DEPTH words in the SRL plus one in the output register.
// Ports:
//   clk       : single clock, rising edge
//   ap_rst_n  : synchronous active-low reset
//   bus       : start_srl_fifo_ctrl_if.slave handshake bundle
//   err       : sticky protocol-error flag
// Optional feature: define START_FIFO_PROTOCOL_CHECK_EN to make err flag
// writes while full and reads while empty; otherwise err is tied low.
module start_srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        ap_rst_n,
    start_srl_fifo_ctrl_if.slave        bus,
    output logic                        err
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CAP_C   = (ADDR_WIDTH+1)'(DEPTH + 1);

    logic [DATA_WIDTH-1:0] srl_sig [DEPTH];
    logic [ADDR_WIDTH:0]   srl_cnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] dout_q;

    logic                  full_n;
    logic                  push;
    logic                  pop;
    logic                  xfer;
    logic [ADDR_WIDTH:0]   cnt_m1;
    logic [ADDR_WIDTH-1:0] head_addr;

    assign full_n    = (srl_cnt != DEPTH_C);
    assign push      = bus.if_write & bus.if_write_ce & full_n;
    assign pop       = bus.if_read & bus.if_read_ce & out_valid;
    // Refill the output stage whenever it is empty or being drained this cycle.
    assign xfer      = (srl_cnt != '0) & (~out_valid | pop);
    // Newest word sits at index 0, so the oldest is at srl_cnt-1.
    assign cnt_m1    = srl_cnt - 1'b1;
    assign head_addr = cnt_m1[ADDR_WIDTH-1:0];

    // SRL storage is not reset; srl_cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (ap_rst_n && push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                srl_sig[i] <= srl_sig[i-1];
            end
            srl_sig[0] <= bus.if_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            srl_cnt   <= '0;
            out_valid <= 1'b0;
            dout_q    <= '0;
        end else begin
            if (xfer) begin
                dout_q    <= srl_sig[head_addr];
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            srl_cnt <= srl_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(xfer);
        end
    end

`ifdef START_FIFO_PROTOCOL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            err_q <= 1'b0;
        end else if ((bus.if_write & bus.if_write_ce & ~full_n) |
                     (bus.if_read & bus.if_read_ce & ~out_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.if_full_n         = full_n;
    assign bus.if_empty_n        = out_valid;
    assign bus.if_dout           = dout_q;
    assign bus.if_num_data_valid = srl_cnt + (ADDR_WIDTH+1)'(out_valid);
    assign bus.if_fifo_cap       = CAP_C;
endmodule

// File: tb/tb_start_srl_fifo_ctrl.sv
module tb_start_srl_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 1;
    localparam int DEPTH = 2;
`ifdef START_FIFO_PROTOCOL_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk = 1'b0;
    logic ap_rst_n;
    logic err;

    always #5 clk = ~clk;

    start_srl_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    start_srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus.slave),
        .err      (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: SRL as a queue (front = oldest) plus the output stage.
    int m_srl[$];
    int m_ov;
    int m_dout;
    int m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int rst_n, input int wce, input int w, input int din,
                              input int rce, input int r);
        int full_n, push, pop, xfer;
        if (rst_n == 0) begin
            m_srl.delete();
            m_ov = 0; m_dout = 0; m_err = 0;
        end else begin
            full_n = (m_srl.size() != DEPTH);
            push   = w & wce & full_n;
            pop    = r & rce & m_ov;
            xfer   = (m_srl.size() != 0) && (!m_ov || pop);
            if (CHK != 0 && ((w & wce & !full_n) || (r & rce & !m_ov))) m_err = 1;
            if (xfer) begin
                m_dout = m_srl.pop_front();
                m_ov   = 1;
            end else if (pop) begin
                m_ov = 0;
            end
            if (push) m_srl.push_back(din);
        end
    endtask

    task automatic compare_all();
        chk("full_n",  int'(bus.if_full_n),  (m_srl.size() != DEPTH) ? 1 : 0);
        chk("empty_n", int'(bus.if_empty_n), m_ov);
        chk("dout",    int'(bus.if_dout),    m_dout);
        chk("count",   int'(bus.if_num_data_valid), m_srl.size() + m_ov);
        chk("cap",     int'(bus.if_fifo_cap), DEPTH + 1);
        chk("err",     int'(err),             m_err);
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 time unit later.
    task automatic step(input int rst_n, input int wce, input int w, input int din,
                        input int rce, input int r);
        ap_rst_n        = rst_n[0];
        bus.if_write_ce = wce[0];
        bus.if_write    = w[0];
        bus.if_din      = din[DW-1:0];
        bus.if_read_ce  = rce[0];
        bus.if_read     = r[0];
        @(posedge clk);
        model_edge(rst_n, wce, w, din & 8'hFF, rce, r);
        #1;
        compare_all();
    endtask

    task automatic wr(input int d);   step(1, 1, 1, d, 1, 0); endtask
    task automatic rd();              step(1, 1, 0, 0, 1, 1); endtask
    task automatic idle();            step(1, 1, 0, 0, 1, 0); endtask
    task automatic rst();             step(0, 1, 0, 0, 1, 0); endtask

    initial begin
        m_ov = 0; m_dout = 0; m_err = 0;
        ap_rst_n = 1'b0;
        bus.if_write_ce = 1'b0; bus.if_write = 1'b0; bus.if_din = '0;
        bus.if_read_ce  = 1'b0; bus.if_read  = 1'b0;
        #2;

        rst(); rst();
        chk("rst_full_n",  int'(bus.if_full_n), 1);
        chk("rst_empty_n", int'(bus.if_empty_n), 0);
        chk("rst_dout",    int'(bus.if_dout), 0);
        chk("rst_count",   int'(bus.if_num_data_valid), 0);
        chk("rst_err",     int'(err), 0);

        // First-word latency
        wr(8'h0A);
        chk("lat_empty_n_1", int'(bus.if_empty_n), 0);
        idle();
        chk("lat_empty_n_2", int'(bus.if_empty_n), 1);
        chk("lat_dout",      int'(bus.if_dout), 8'h0A);
        chk("lat_count",     int'(bus.if_num_data_valid), 1);
        rd();
        chk("lat_pop_count",   int'(bus.if_num_data_valid), 0);
        chk("lat_pop_empty_n", int'(bus.if_empty_n), 0);

        // Fill to capacity, then a simultaneous write/read while full
        wr(1); wr(2); wr(3);
        chk("full_full_n", int'(bus.if_full_n), 0);
        chk("full_count",  int'(bus.if_num_data_valid), 3);
        chk("full_head",   int'(bus.if_dout), 1);
        step(1, 1, 1, 8'h55, 1, 1);
        chk("fullrw_count",  int'(bus.if_num_data_valid), 2);
        chk("fullrw_full_n", int'(bus.if_full_n), 1);
        chk("fullrw_dout",   int'(bus.if_dout), 2);
        rd();
        chk("order_3", int'(bus.if_dout), 3);
        chk("order_count", int'(bus.if_num_data_valid), 1);
        rd();
        chk("drain_empty_n", int'(bus.if_empty_n), 0);

        // Steady-state streaming: one word in output stage, one in SRL
        wr(100); idle(); wr(101);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, 102 + i, 1, 1);
            chk("stream_dout",  int'(bus.if_dout), 101 + i);
            chk("stream_count", int'(bus.if_num_data_valid), 2);
        end
        rd(); rd(); idle();
        chk("stream_drained", int'(bus.if_empty_n), 0);

        // Protocol error: read while empty, sticky until reset
        rd();
        chk("err_set", int'(err), CHK);
        wr(7); idle(); rd();
        chk("err_sticky", int'(err), CHK);
        rst();
        chk("err_cleared", int'(err), 0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0) ? 0 : 1,
                 ($urandom_range(0, 7) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
